theia_wb_scene_mem: RTL and testbench

- Wishbone classic slave that sits directly downstream of the THEIA top-level master bus.
- Consumes the arbitrated ADR/DAT/WE/STB/CYC/TGA outputs and returns ACK and read data to the cores.
- Holds three on-chip scene memory banks selected by address tag: geometry, parameters and frame output.
- A host preload port fills the banks before rendering starts.

---
 rtl/theia_wb_scene_mem.sv | 165 ++++++++++++++++
 tb/tb_theia_wb_scene_mem.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/theia_wb_scene_mem.sv
// Wishbone classic slave with three scene banks (geometry, params, frame) plus a host preload port.
// Optional reserved-tag error counter enabled by defining THEIA_SCENE_MEM_ERRCNT_EN.
module theia_wb_scene_mem #(
    parameter int WB_WIDTH    = 32,
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic [WB_WIDTH-1:0]  ADR_I,
    input  logic [WB_WIDTH-1:0]  DAT_I,
    input  logic                 WE_I,
    input  logic                 STB_I,
    input  logic                 CYC_I,
    input  logic [1:0]           TGA_I,
    output logic [WB_WIDTH-1:0]  DAT_O,
    output logic                 ACK_O,
    input  logic                 HWE_I,
    input  logic [1:0]           HTGA_I,
    input  logic [ADDR_BITS-1:0] HADR_I,
    input  logic [WB_WIDTH-1:0]  HDAT_I,
    output logic                 BUSY_O
`ifdef THEIA_SCENE_MEM_ERRCNT_EN
    ,
    output logic [15:0]          ERRCNT_O,
    output logic                 ERR_O
`endif
);
    // state  | meaning
    // S_IDLE | waiting for a request; host writes block acceptance
    // S_WAIT | request latched, counting down wait states
    // S_ACK  | ACK_O high for one cycle, read data valid
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] WS_LD = 4'(WAIT_STATES);

    state_t state, state_nxt;
    logic [3:0]           cnt;
    logic [ADDR_BITS-1:0] lat_adr;
    logic [1:0]           lat_tga;
    logic                 lat_we;
    logic [WB_WIDTH-1:0]  lat_dat;
    logic                 req, accept, finish;
    logic [ADDR_BITS-1:0] xfer_adr;
    logic [1:0]           xfer_tga;
    logic                 xfer_we;
    logic [WB_WIDTH-1:0]  xfer_dat;
    logic [WB_WIDTH-1:0]  rd_word;

    logic [WB_WIDTH-1:0] mem_geo [DEPTH];
    logic [WB_WIDTH-1:0] mem_par [DEPTH];
    logic [WB_WIDTH-1:0] mem_frm [DEPTH];

    wire unused_adr_hi = ^ADR_I[WB_WIDTH-1:ADDR_BITS];

    assign req    = STB_I & CYC_I;
    assign BUSY_O = (state != S_IDLE);

    // With zero wait states the transfer completes straight from IDLE, so use live inputs there.
    assign xfer_adr = (state == S_IDLE) ? ADR_I[ADDR_BITS-1:0] : lat_adr;
    assign xfer_tga = (state == S_IDLE) ? TGA_I : lat_tga;
    assign xfer_we  = (state == S_IDLE) ? WE_I  : lat_we;
    assign xfer_dat = (state == S_IDLE) ? DAT_I : lat_dat;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req && !HWE_I) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt = S_ACK;
                        finish    = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (cnt <= 4'd1) begin
                    state_nxt = S_ACK;
                    finish    = 1'b1;
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        case (xfer_tga)
            2'b00:   rd_word = mem_geo[xfer_adr];
            2'b01:   rd_word = mem_par[xfer_adr];
            2'b10:   rd_word = mem_frm[xfer_adr];
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ACK_O   <= 1'b0;
            DAT_O   <= '0;
            lat_adr <= '0;
            lat_tga <= '0;
            lat_we  <= 1'b0;
            lat_dat <= '0;
        end else begin
            state <= state_nxt;
            ACK_O <= finish;
            if (finish && !xfer_we)
                DAT_O <= rd_word;
            if (accept) begin
                lat_adr <= ADR_I[ADDR_BITS-1:0];
                lat_tga <= TGA_I;
                lat_we  <= WE_I;
                lat_dat <= DAT_I;
                cnt     <= WS_LD;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Bus write is issued after the host write so it wins on a same-edge collision.
    always_ff @(posedge CLK_I) begin
        if (HWE_I) begin
            case (HTGA_I)
                2'b00:   mem_geo[HADR_I] <= HDAT_I;
                2'b01:   mem_par[HADR_I] <= HDAT_I;
                2'b10:   mem_frm[HADR_I] <= HDAT_I;
                default: ;
            endcase
        end
        if (finish && xfer_we && !RST_I) begin
            case (xfer_tga)
                2'b00:   mem_geo[xfer_adr] <= xfer_dat;
                2'b01:   mem_par[xfer_adr] <= xfer_dat;
                2'b10:   mem_frm[xfer_adr] <= xfer_dat;
                default: ;
            endcase
        end
    end

`ifdef THEIA_SCENE_MEM_ERRCNT_EN
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            ERRCNT_O <= '0;
            ERR_O    <= 1'b0;
        end else begin
            ERR_O <= finish && (xfer_tga == 2'b11);
            if (finish && (xfer_tga == 2'b11) && ERRCNT_O != 16'hFFFF)
                ERRCNT_O <= ERRCNT_O + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_theia_wb_scene_mem.sv
// Randomized bench for theia_wb_scene_mem against a transaction-level bank model.
// Build with THEIA_SCENE_MEM_ERRCNT_EN defined to also check the error counter.
module tb_theia_wb_scene_mem;
    localparam int W  = 32;
    localparam int AB = 10;
    localparam int WS = 1;

    logic          CLK_I = 1'b0;
    logic          RST_I = 1'b0;
    logic [W-1:0]  ADR_I = '0, DAT_I = '0;
    logic          WE_I = 1'b0, STB_I = 1'b0, CYC_I = 1'b0;
    logic [1:0]    TGA_I = '0;
    logic [W-1:0]  DAT_O;
    logic          ACK_O;
    logic          HWE_I = 1'b0;
    logic [1:0]    HTGA_I = '0;
    logic [AB-1:0] HADR_I = '0;
    logic [W-1:0]  HDAT_I = '0;
    logic          BUSY_O;
`ifdef THEIA_SCENE_MEM_ERRCNT_EN
    logic [15:0]   ERRCNT_O;
    logic          ERR_O;
    int            ref_err = 0;
`endif

    theia_wb_scene_mem #(.WB_WIDTH(W), .ADDR_BITS(AB), .WAIT_STATES(WS)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .ADR_I(ADR_I), .DAT_I(DAT_I), .WE_I(WE_I),
        .STB_I(STB_I), .CYC_I(CYC_I), .TGA_I(TGA_I), .DAT_O(DAT_O), .ACK_O(ACK_O),
        .HWE_I(HWE_I), .HTGA_I(HTGA_I), .HADR_I(HADR_I), .HDAT_I(HDAT_I), .BUSY_O(BUSY_O)
`ifdef THEIA_SCENE_MEM_ERRCNT_EN
        , .ERRCNT_O(ERRCNT_O), .ERR_O(ERR_O)
`endif
    );

    always #5 CLK_I = ~CLK_I;

    logic [W-1:0] ref_mem [0:3][0:(1<<AB)-1];
    logic [W-1:0] last_rd = '0;
    int n_cmp = 0, n_mis = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK_I);
        #1;
    endtask

    task automatic model_host(input logic [1:0] t, input logic [AB-1:0] a, input logic [W-1:0] d);
        if (t != 2'b11) ref_mem[t][a] = d;
    endtask

    task automatic host_wr(input logic [1:0] t, input logic [AB-1:0] a, input logic [W-1:0] d);
        HWE_I = 1'b1; HTGA_I = t; HADR_I = a; HDAT_I = d;
        tick;
        HWE_I = 1'b0;
        model_host(t, a, d);
    endtask

    // hold: cycles HWE_I stays high alongside the request; hw_wait: host write during WAIT.
    task automatic bus_xfer(input logic we, input logic [1:0] tga, input logic [W-1:0] adr,
                            input logic [W-1:0] dat, input int hold, input logic hw_wait,
                            input logic [1:0] ht, input logic [AB-1:0] ha, input logic [W-1:0] hd);
        int n;
        logic got_ack;
        logic [W-1:0] exp_rd;
        logic [AB-1:0] a;
        a = adr[AB-1:0];
        if (hold > 0) model_host(ht, ha, hd);
        exp_rd = (tga == 2'b11) ? '0 : ref_mem[tga][a];
        if (hw_wait) model_host(ht, ha, hd);
        if (we && tga != 2'b11) ref_mem[tga][a] = dat;
        if (!we) last_rd = exp_rd;
        STB_I = 1'b1; CYC_I = 1'b1; WE_I = we; TGA_I = tga; ADR_I = adr; DAT_I = dat;
        HTGA_I = ht; HADR_I = ha; HDAT_I = hd; HWE_I = (hold > 0);
        n = 0; got_ack = 1'b0;
        while (n < 40 && !got_ack) begin
            tick;
            n++;
            got_ack = ACK_O;
            if (hold > 0 && n == hold) begin
                chk("busy_hold", {31'b0, BUSY_O}, 32'd0);
                HWE_I = 1'b0;
            end
            if (n == hold + 1 && WS > 0) begin
                chk("busy_wait", {31'b0, BUSY_O}, 32'd1);
                if (hw_wait) HWE_I = 1'b1;
            end
            if (n == hold + 2) HWE_I = 1'b0;
        end
        STB_I = 1'b0; CYC_I = 1'b0; WE_I = 1'b0; HWE_I = 1'b0;
        chk("ack", {31'b0, got_ack}, 32'd1);
        chk("latency", 32'(n), 32'(hold + WS + 1));
        chk(we ? "dat_hold" : "rdata", DAT_O, last_rd);
`ifdef THEIA_SCENE_MEM_ERRCNT_EN
        if (tga == 2'b11 && ref_err < 16'hFFFF) ref_err++;
        chk("err_pulse", {31'b0, ERR_O}, {31'b0, tga == 2'b11});
        chk("errcnt", {16'b0, ERRCNT_O}, 32'(ref_err));
`endif
        tick;
        chk("ack_one", {31'b0, ACK_O}, 32'd0);
        chk("busy_end", {31'b0, BUSY_O}, 32'd0);
`ifdef THEIA_SCENE_MEM_ERRCNT_EN
        chk("err_end", {31'b0, ERR_O}, 32'd0);
`endif
    endtask

    task automatic rd(input logic [1:0] tga, input logic [W-1:0] adr);
        bus_xfer(1'b0, tga, adr, '0, 0, 1'b0, 2'b00, '0, '0);
    endtask

    task automatic wr(input logic [1:0] tga, input logic [W-1:0] adr, input logic [W-1:0] dat);
        bus_xfer(1'b1, tga, adr, dat, 0, 1'b0, 2'b00, '0, '0);
    endtask

    // Starts a transfer, then kills it in WAIT by dropping STB_I or by reset.
    task automatic abort_xfer(input logic use_rst, input logic we, input logic [1:0] tga,
                              input logic [W-1:0] adr, input logic [W-1:0] dat);
        STB_I = 1'b1; CYC_I = 1'b1; WE_I = we; TGA_I = tga; ADR_I = adr; DAT_I = dat;
        tick;
        chk("abort_busy", {31'b0, BUSY_O}, 32'd1);
        if (use_rst) RST_I = 1'b1;
        else STB_I = 1'b0;
        tick;
        chk("abort_ack", {31'b0, ACK_O}, 32'd0);
        chk("abort_idle", {31'b0, BUSY_O}, 32'd0);
        RST_I = 1'b0; STB_I = 1'b0; CYC_I = 1'b0; WE_I = 1'b0;
        if (use_rst) begin
            last_rd = '0;
            chk("rst_dat", DAT_O, 32'd0);
`ifdef THEIA_SCENE_MEM_ERRCNT_EN
            ref_err = 0;
`endif
        end
        tick;
        chk("abort_ack2", {31'b0, ACK_O}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [AB-1:0] ha;
        logic [1:0] rt, ht;
        int op;

        RST_I = 1'b1;
        tick; tick;
        RST_I = 1'b0;
        chk("rst_ack", {31'b0, ACK_O}, 32'd0);
        chk("rst_busy", {31'b0, BUSY_O}, 32'd0);
        chk("rst_dat", DAT_O, 32'd0);

        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 16; i++)
                host_wr(2'(b), 10'(i), $urandom);
        host_wr(2'b00, 10'd5, 32'hDEADBEEF);

        rd(2'b00, 32'd5);
        chk("geo5", DAT_O, 32'hDEADBEEF);
        wr(2'b10, 32'd3, 32'h0000_1234);
        rd(2'b10, 32'd3);
        chk("frm3", DAT_O, 32'h0000_1234);
        rd(2'b01, 32'd3);
        bus_xfer(1'b0, 2'b00, 32'd9, '0, 3, 1'b0, 2'b01, 10'd12, 32'h5A5A_0001);
        abort_xfer(1'b0, 1'b1, 2'b00, 32'd7, 32'hAAAA_5555);
        rd(2'b00, 32'd7);
        rd(2'b00, 32'h0000_0405);
        chk("wrap", DAT_O, 32'hDEADBEEF);
        rd(2'b11, 32'd5);
        chk("rsvd_rd", DAT_O, 32'd0);
        wr(2'b11, 32'd5, 32'h1111_2222);
        rd(2'b00, 32'd5);
        abort_xfer(1'b1, 1'b1, 2'b01, 32'd4, 32'hCAFE_F00D);
        rd(2'b01, 32'd4);
        // Host write landing on the WAIT->ACK edge: read sees old data, bus write wins.
        bus_xfer(1'b0, 2'b00, 32'd2, '0, 0, 1'b1, 2'b00, 10'd2, 32'hB0B0_B0B0);
        rd(2'b00, 32'd2);
        bus_xfer(1'b1, 2'b01, 32'd6, 32'h0606_0606, 0, 1'b1, 2'b01, 10'd6, 32'hFFFF_0000);
        rd(2'b01, 32'd6);

        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 5);
            rt = 2'($urandom_range(0, 3));
            ra = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
            ht = 2'($urandom_range(0, 3));
            ha = $urandom_range(0, 1) ? ra[AB-1:0] : 10'($urandom_range(0, 15));
            case (op)
                0: host_wr(ht, ha, $urandom);
                1: rd(rt, ra);
                2: wr(rt, ra, $urandom);
                3: bus_xfer($urandom_range(0, 1) == 1, rt, ra, $urandom,
                            $urandom_range(1, 3), 1'b0, ht, ha, $urandom);
                4: bus_xfer($urandom_range(0, 1) == 1, rt, ra, $urandom,
                            0, 1'b1, ht, ha, $urandom);
                default: abort_xfer(1'b0, 1'b1, rt, ra, $urandom);
            endcase
        end
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 16; i++)
                rd(2'(b), 32'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
